// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the helpers that decide legality and build store lane data.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // Alignment and encoding check; unsigned sizes exist only for loads.
  function automatic logic is_legal(input logic write, input logic [2:0] funct3,
                                    input logic [1:0] offset);
    logic ok;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~offset[0];
      F3_W:    ok = (offset == 2'b00);
      F3_BU:   ok = ~write;
      F3_HU:   ok = ~write & ~offset[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] offset);
    logic [3:0] en;
    case (funct3)
      F3_B, F3_BU: en = 4'b0001 << offset;
      F3_H, F3_HU: en = offset[1] ? 4'b1100 : 4'b0011;
      default:     en = 4'b1111;
    endcase
    return en;
  endfunction

  // Replicate the store operand across lanes so the byte enables pick it out.
  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    logic [31:0] d;
    case (funct3)
      F3_B, F3_BU: d = {4{wdata[7:0]}};
      F3_H, F3_HU: d = {2{wdata[15:0]}};
      default:     d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/halfword from a bus word and sign- or
// zero-extends it; a full word passes through.
module load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  // Size/sign selection on the lane-aligned word
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory instruction from the core, runs the bus
// request and read-response handshakes, formats load data and stalls the
// core until the access completes, faults or times out.
//
// Bus handshake: BusValid is raised in REQ with address/we/data/enables held
// stable; the request is accepted on the first cycle with BusValid & BusReady
// and BusValid drops the following cycle. A load response is taken only in
// WAIT, i.e. on a BusRValid cycle strictly after acceptance.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReq,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       DataMemRead,
  output logic              Stall,
  output logic              AccessFault,
  output logic              BusError,
  output logic              BusValid,
  input  logic              BusReady,
  output logic              BusWe,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [31:0]       BusWData,
  output logic [3:0]        BusByteEn,
  input  logic              BusRValid,
  input  logic [31:0]       BusRData,
  output lsu_state_t        debug_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t     state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [1:0]     offset_q;
  logic [2:0]     funct3_q;
  logic           legal;
  logic           take;
  logic           tmo_hit;
  logic [31:0]    load_data;

  assign legal       = is_legal(MemWrite, Funct3, Address[1:0]);
  assign take        = (state == IDLE) && MemReq && legal;
  assign Stall       = take || (state == REQ) || (state == WAIT);
  // ">=" so an acceptance on the last allowed cycle still aborts in WAIT.
  assign tmo_hit     = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign debug_state = state;

  load_formatter u_load_formatter (
    .rdata  (BusRData),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  // Access FSM with registered bus outputs, result and fault pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      offset_q    <= '0;
      funct3_q    <= '0;
      DataMemRead <= '0;
      AccessFault <= 1'b0;
      BusError    <= 1'b0;
      BusValid    <= 1'b0;
      BusWe       <= 1'b0;
      BusAddr     <= '0;
      BusWData    <= '0;
      BusByteEn   <= '0;
    end else begin
      AccessFault <= 1'b0;
      BusError    <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (MemReq) begin
            if (legal) begin
              offset_q  <= Address[1:0];
              funct3_q  <= Funct3;
              BusAddr   <= {Address[ADDR_W-1:2], 2'b00};
              BusWe     <= MemWrite;
              BusWData  <= store_data(Funct3, WriteData);
              BusByteEn <= byte_en(Funct3, Address[1:0]);
              BusValid  <= 1'b1;
              state     <= REQ;
            end else begin
              AccessFault <= 1'b1;
            end
          end
        end
        REQ: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (BusReady) begin
            BusValid <= 1'b0;
            state    <= BusWe ? DONE : WAIT;
          end else if (tmo_hit) begin
            BusValid    <= 1'b0;
            BusError    <= 1'b1;
            DataMemRead <= '0;
            state       <= DONE;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
          if (BusRValid) begin
            DataMemRead <= load_data;
            state       <= DONE;
          end else if (tmo_hit) begin
            BusError    <= 1'b1;
            DataMemRead <= '0;
            state       <= DONE;
          end
        end
        default: begin
          tmo_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: drivers push expected bus requests and
// responses into queues; negedge monitors pop and compare them.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReq, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Address, WriteData;
  logic [31:0] DataMemRead;
  logic        Stall, AccessFault, BusError, BusValid, BusReady, BusWe;
  logic [31:0] BusAddr, BusWData, BusRData;
  logic [3:0]  BusByteEn;
  logic        BusRValid;
  lsu_state_t  debug_state;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cnt = 0;
  int bv_cnt = 0;
  int resp_cnt = 0;
  int s0, b0, r0;

  logic [68:0] req_q[$];
  logic [34:0] exp_q[$];

  // Clock
  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite),
    .Funct3(Funct3), .Address(Address), .WriteData(WriteData),
    .DataMemRead(DataMemRead), .Stall(Stall), .AccessFault(AccessFault),
    .BusError(BusError), .BusValid(BusValid), .BusReady(BusReady),
    .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData),
    .BusByteEn(BusByteEn), .BusRValid(BusRValid), .BusRData(BusRData),
    .debug_state(debug_state)
  );

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: activity counters plus request and response scoreboards
  always @(negedge clk) begin
    if (!reset) begin
      if (Stall) stall_cnt++;
      if (BusValid) bv_cnt++;
      if (BusValid && BusReady) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_req: unexpected request addr %h", BusAddr);
        end else chk("bus_req", {BusWe, BusAddr, BusWData, BusByteEn}, req_q.pop_front());
      end
      if (AccessFault || debug_state == DONE) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp: unexpected response data %h", DataMemRead);
        end else chk("resp", {AccessFault, BusError, Stall, DataMemRead}, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(posedge clk); #1;
    MemReq = 1'b1; MemWrite = we; Funct3 = f3; Address = addr; WriteData = wd;
    @(posedge clk); #1;
    MemReq = 1'b0;
  endtask

  task automatic bus_accept(input int dly);
    for (int i = 0; i < dly; i++) begin @(posedge clk); #1; end
    BusReady = 1'b1;
    @(posedge clk); #1;
    BusReady = 1'b0;
  endtask

  task automatic bus_resp(input int dly, input logic [31:0] d);
    for (int i = 1; i < dly; i++) begin @(posedge clk); #1; end
    BusRValid = 1'b1; BusRData = d;
    @(posedge clk); #1;
    BusRValid = 1'b0; BusRData = '0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd,
                      input logic [31:0] bus_addr, input logic [3:0] be,
                      input logic [31:0] exp_data, input int rdly, input int exp_stall);
    req_q.push_back({1'b0, bus_addr, 32'h0, be});
    exp_q.push_back({3'b000, exp_data});
    s0 = stall_cnt;
    issue(1'b0, f3, addr, 32'h0);
    bus_accept(0);
    bus_resp(rdly, rd);
    settle();
    chk("load_stall_cycles", 69'(stall_cnt - s0), 69'(exp_stall));
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] bus_addr, input logic [31:0] bus_wd,
                       input logic [3:0] be, input logic [31:0] held);
    req_q.push_back({1'b1, bus_addr, bus_wd, be});
    exp_q.push_back({3'b000, held});
    s0 = stall_cnt;
    issue(1'b1, f3, addr, wd);
    bus_accept(0);
    settle();
    chk("store_stall_cycles", 69'(stall_cnt - s0), 69'd2);
  endtask

  task automatic fault(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] held);
    exp_q.push_back({3'b100, held});
    s0 = stall_cnt; b0 = bv_cnt;
    issue(we, f3, addr, 32'h0);
    settle();
    chk("fault_stall_cycles", 69'(stall_cnt - s0), 69'd0);
    chk("fault_busvalid_cycles", 69'(bv_cnt - b0), 69'd0);
  endtask

  // Stimulus
  initial begin
    reset = 1'b1; MemReq = 0; MemWrite = 0; Funct3 = 0; Address = 0; WriteData = 0;
    BusReady = 0; BusRValid = 0; BusRData = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", debug_state, IDLE);
    chk("rst_outputs", {DataMemRead, BusValid, BusWe, AccessFault, BusError, Stall}, 69'h0);
    chk("rst_bus", {BusAddr, BusWData, BusByteEn}, 69'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    load(F3_W,  32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF, 2, 4);
    load(F3_B,  32'h103, 32'h80FF1234, 32'h100, 4'b1000, 32'hFFFFFF80, 1, 3);
    load(F3_BU, 32'h103, 32'h80FF1234, 32'h100, 4'b1000, 32'h00000080, 1, 3);
    load(F3_H,  32'h102, 32'h80011234, 32'h100, 4'b1100, 32'hFFFF8001, 1, 3);
    load(F3_HU, 32'h102, 32'h80011234, 32'h100, 4'b1100, 32'h00008001, 1, 3);

    store(F3_H, 32'h202, 32'h0000ABCD, 32'h200, 32'hABCDABCD, 4'b1100, 32'h00008001);
    store(F3_B, 32'h201, 32'h1234565A, 32'h200, 32'h5A5A5A5A, 4'b0010, 32'h00008001);
    store(F3_W, 32'h300, 32'h11223344, 32'h300, 32'h11223344, 4'b1111, 32'h00008001);

    fault(1'b0, F3_W,   32'h101, 32'h00008001);
    fault(1'b1, F3_BU,  32'h000, 32'h00008001);
    fault(1'b0, 3'b011, 32'h000, 32'h00008001);

    // Timeout: request never accepted
    exp_q.push_back({3'b010, 32'h0});
    s0 = stall_cnt; b0 = bv_cnt; r0 = resp_cnt;
    issue(1'b0, F3_H, 32'h10, 32'h0);
    for (int i = 0; i < 40 && resp_cnt == r0; i++) @(posedge clk);
    if (resp_cnt == r0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_wait: no completion within 40 cycles, expected BusError");
    end
    settle();
    chk("timeout_busvalid_cycles", 69'(bv_cnt - b0), 69'(TMO));
    chk("timeout_stall_cycles", 69'(stall_cnt - s0), 69'(TMO + 1));

    // Reset while waiting for read data, then a late response
    req_q.push_back({1'b0, 32'h40, 32'h0, 4'b1111});
    r0 = resp_cnt;
    issue(1'b0, F3_W, 32'h40, 32'h0);
    bus_accept(0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; BusRValid = 1'b1; BusRData = 32'h12345678;
    @(negedge clk);
    chk("midrst_state", debug_state, IDLE);
    chk("midrst_outputs", {DataMemRead, Stall, BusValid}, 69'h0);
    @(posedge clk); #1;
    BusRValid = 1'b0; BusRData = '0;
    @(negedge clk);
    chk("midrst_late_rvalid", {DataMemRead, Stall, BusValid}, 69'h0);
    settle();
    chk("midrst_no_done", 69'(resp_cnt - r0), 69'd0);

    chk("req_q_empty", 69'(req_q.size()), 69'd0);
    chk("exp_q_empty", 69'(exp_q.size()), 69'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side producer of DataMemRead for the writeback select stage.
- Accepts one load/store per instruction from the core datapath.
- Runs a valid/ready request and rvalid response handshake to a data bus, and formats load data (byte/half extraction, sign/zero extension).
- Drives Stall to freeze the PC and register writeback until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255, bus cycles allowed in REQ+WAIT before the access is aborted with BusError.
- ADDR_W, 32, address width (data path is fixed at 32 bits).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- MemReq  in  1  current instruction is a load/store
- MemWrite  in  1  1=store, 0=load
- Funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- Address  in  ADDR_W  byte address (ALUResult)
- WriteData  in  32  store source register value
- DataMemRead  out  32  formatted load data, valid in DONE
- Stall  out  1  freeze core this cycle
- AccessFault  out  1  one-cycle pulse: misaligned or illegal Funct3
- BusError  out  1  one-cycle pulse: timeout abort
- BusValid  out  1  request valid
- BusReady  in  1  request accepted
- BusWe  out  1  write request
- BusAddr  out  ADDR_W  word-aligned address (Address[1:0] forced 00)
- BusWData  out  32  lane-replicated store data
- BusByteEn  out  4  byte lane enables
- BusRValid  in  1  read data valid
- BusRData  in  32  read data word

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset forces IDLE. All registered outputs are 0 after reset: DataMemRead, BusValid, BusWe, BusAddr, BusWData, BusByteEn, AccessFault, BusError. The timeout counter resets to 0.
- Legality check in IDLE:
  - H/HU requires Address[0]=0.
  - W requires Address[1:0]=00.
  - Funct3 011/110/111 is illegal for any access; 100/101 is illegal for stores.
- IDLE, MemReq=1 and illegal: AccessFault=1 next cycle for one cycle. No bus activity, Stall=0, stay IDLE.
- IDLE, MemReq=1 and legal: latch address, size, sign, write data and byte enables; go to REQ.
- Stall is combinational: 1 when (IDLE & MemReq & legal) or state is REQ or WAIT; 0 in DONE.
- REQ:
  - BusValid=1. BusAddr/BusWe/BusWData/BusByteEn stay constant until accepted.
  - Handshake completes on the cycle with BusValid & BusReady. BusValid drops next cycle.
  - On accept, a store goes to DONE and a load goes to WAIT.
- WAIT: on BusRValid, register the formatted BusRData into DataMemRead and go to DONE.
  - If BusRValid arrives in the same cycle as BusReady, it is ignored; the response must come after acceptance.
- DONE: lasts one cycle with Stall=0, so the core commits and advances. MemReq is ignored in this cycle. Next state is IDLE.
- Timeout:
  - The counter increments every cycle in REQ or WAIT and clears in IDLE.
  - On reaching TIMEOUT_CYCLES, BusValid drops, BusError pulses for one cycle, DataMemRead=0, go to DONE.
- Store formatting:
  - SB: byte replicated to all 4 lanes, ByteEn = 0001 << Address[1:0].
  - SH: halfword replicated, ByteEn = 0011 (A[1]=0) or 1100 (A[1]=1).
  - SW: ByteEn = 1111.
- Load formatting: select lane by the latched Address[1:0]. B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.
- DataMemRead holds its last value outside DONE. A store leaves it unchanged.
- Reset mid-access: the state returns to IDLE immediately, BusValid=0 next cycle, and a late BusRValid/BusReady in IDLE is ignored.

Decomposition:
- Shared package lsu_pkg:
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - Function for the legality check.
- Sub-module load_formatter (combinational): inputs rdata[31:0], offset[1:0], funct3[2:0]; output 32-bit formatted data. It is reused by any future cache fill path.

Test Plan:
- LW at 0x100, BusReady after 1 cycle, BusRValid 2 cycles later with 0xDEADBEEF:
  - BusAddr=0x100, ByteEn=1111, Stall high 4 cycles, DataMemRead=0xDEADBEEF in DONE.
- LB at 0x103 / LBU at 0x103, BusRData=0x80FF1234 -> DataMemRead=0xFFFFFF80 / 0x00000080.
- SH at 0x202, WriteData=0x0000ABCD, BusReady immediately:
  - BusAddr=0x200, BusWData=0xABCDABCD, ByteEn=1100, BusWe=1, DONE after 2 cycles, DataMemRead unchanged.
- LW at 0x101 -> AccessFault one pulse, BusValid never asserted, Stall=0.
- SB with Funct3=100 -> AccessFault one pulse, BusValid never asserted, Stall=0.
- LH at 0x10, BusReady held low, TIMEOUT_CYCLES=8:
  - BusValid high 8 cycles, BusError pulse, DataMemRead=0, Stall low in DONE.
- Reset asserted while in WAIT, then BusRValid=1 with 0x12345678 the cycle after reset:
  - State IDLE, DataMemRead=0, no DONE, Stall=0.
